// File: rtl/ls_pkg.sv
// Shared types for the LS frame packer and its FIFO.
package ls_pkg;

  localparam int unsigned LS_BYTES = 8;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } LS;

  typedef struct packed {
    LS    ls;
    logic short_f;
  } ls_entry_t;

  typedef enum logic [0:0] {
    StFillA,
    StFillB
  } asm_state_e;

endpackage

// File: rtl/ls_frame_packer_if.sv
// Byte-stream input and LS-struct output handshakes of the frame packer.
interface ls_frame_packer_if;
  import ls_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  LS          out_ls;
  logic       out_short;

  // Source of bytes and sink of structs.
  modport master (
    output in_valid, in_byte, in_last, out_ready,
    input  in_ready, out_valid, out_ls, out_short
  );

  // The packer itself.
  modport slave (
    input  in_valid, in_byte, in_last, out_ready,
    output in_ready, out_valid, out_ls, out_short
  );

endinterface

// File: rtl/ls_fifo2.sv
// Two-entry FIFO of ls_entry_t. Slot 0 is always the head; a pop shifts slot 1 down.
module ls_fifo2
  import ls_pkg::*;
(
  input  logic      clock,
  input  logic      reset_n,
  input  logic      push,
  input  ls_entry_t wdata,
  input  logic      pop,
  output ls_entry_t rdata,
  output logic [1:0] count
);

  ls_entry_t  mem_q [2];
  ls_entry_t  mem_d [2];
  logic [1:0] count_q, count_d;
  logic [1:0] wr_ptr;

  // Next-state: shift on pop, then write at the slot left free after the pop.
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    count_d  = count_q;
    wr_ptr   = count_q - {1'b0, pop};
    if (pop) begin
      mem_d[0] = mem_q[1];
      mem_d[1] = '0;
    end
    if (push) begin
      mem_d[wr_ptr[0]] = wdata;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // Storage and occupancy registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      count_q  <= '0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[0];
  assign count = count_q;

endmodule

// File: rtl/ls_frame_packer.sv
// Packs byte frames of up to 8 bytes into LS structs {a, b}, buffered in a 2-entry FIFO.
module ls_frame_packer
  import ls_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  ls_frame_packer_if.slave bus,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [2:0] LastIdx = 3'(LS_BYTES - 1);

  asm_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  LS          asm_q, asm_d, asm_nxt;
  logic [CNT_W-1:0] cnt_q;

  logic       accept, close, pop;
  ls_entry_t  push_entry, head;
  logic [1:0] fifo_count;

  assign accept = bus.in_valid && bus.in_ready;
  assign close  = accept && (bus.in_last || idx_q == LastIdx);
  assign pop    = bus.out_valid && bus.out_ready;

  // Assembler: merge the incoming byte, then advance or close the frame.
  always_comb begin
    asm_nxt = asm_q;
    if (state_q == StFillB) begin
      asm_nxt.b[{idx_q[1:0], 3'b000} +: 8] = bus.in_byte;
    end else begin
      asm_nxt.a[{idx_q[1:0], 3'b000} +: 8] = bus.in_byte;
    end
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    if (accept) begin
      if (close) begin
        state_d = StFillA;
        idx_d   = '0;
        asm_d   = '0;
      end else begin
        idx_d   = idx_q + 3'd1;
        asm_d   = asm_nxt;
        state_d = idx_d[2] ? StFillB : StFillA;
      end
    end
    push_entry.ls      = asm_nxt;
    push_entry.short_f = (idx_q != LastIdx);
  end

  // Assembler state, byte index, partial struct and frame counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFillA;
      idx_q   <= '0;
      asm_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      if (pop) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  ls_fifo2 u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (close),
    .wdata   (push_entry),
    .pop     (pop),
    .rdata   (head),
    .count   (fifo_count)
  );

  // Output decode; head fields are forced to zero while the FIFO is empty.
  always_comb begin
    bus.in_ready  = (fifo_count != 2'(FIFO_DEPTH));
    bus.out_valid = (fifo_count != 2'd0);
    bus.out_ls    = bus.out_valid ? head.ls : '0;
    bus.out_short = bus.out_valid ? head.short_f : 1'b0;
  end

  assign frame_cnt = cnt_q;

endmodule
